// File: rtl/obstacle_engine_if.sv
// obstacle_engine_if: game-side signal bundle of the obstacle engine.
// The master drives tick/run control and player inputs; the slave (the engine) returns field and status.
interface obstacle_engine_if #(
    parameter int DEPTH = 16
);
    logic               pulse;
    logic               playing;
    logic               reset_game;
    logic [1:0]         lane;
    logic               jump;
    logic               died;
    logic               airborne;
    logic [3*DEPTH-1:0] obstacles;

    modport master (
        output pulse, playing, reset_game, lane, jump,
        input  died, airborne, obstacles
    );

    modport slave (
        input  pulse, playing, reset_game, lane, jump,
        output died, airborne, obstacles
    );
endinterface

// File: rtl/obstacle_engine.sv
// obstacle_engine: scrolls a 3-lane obstacle field, spawns from an LFSR, tracks jump airtime, flags collisions.
// Optional build macro OBSTACLE_SPEEDUP_EN: shift period shortens by one pulse every 16 shifts (floor 1).
module obstacle_engine #(
    parameter int          DEPTH        = 16,
    parameter int          JUMP_PULSES  = 3,
    parameter int          SPAWN_THRESH = 6,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          START_DIV    = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    obstacle_engine_if.slave bus
);
    localparam int AW = (JUMP_PULSES < 1) ? 1 : $clog2(JUMP_PULSES + 1);
    localparam int DW = $clog2(START_DIV + 1);
    localparam int FW = 3 * DEPTH;

    // Bit n set means a roll of n on lfsr[3:0] spawns; avoids constant-range compares at the extremes.
    localparam logic [15:0] SPAWN_MASK = 16'((17'd1 << SPAWN_THRESH) - 17'd1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DEAD
    } state_e;

    state_e          state_q, state_d;
    logic [FW-1:0]   field_q, field_d, field_sh;
    logic [15:0]     lfsr_q, lfsr_d;
    logic            air_q, air_d;
    logic [AW-1:0]   air_cnt_q, air_cnt_d;
    logic [DW-1:0]   div_q, div_d;
    logic [DW-1:0]   div_cnt_q, div_cnt_d;
    logic            jump_prev_q;
    logic            died_q, died_d;
`ifdef OBSTACLE_SPEEDUP_EN
    logic [3:0]      shift_cnt_q, shift_cnt_d;
`endif

    logic [1:0]      lane_c;
    logic [2:0]      row0;
    logic            hit;
    logic            top_empty;
    logic            spawn;
    logic            div_end;
    logic            jump_edge;

    assign lane_c    = (bus.lane == 2'd3) ? 2'd2 : bus.lane;
    assign row0      = {field_q[2*DEPTH], field_q[DEPTH], field_q[0]};
    assign hit       = row0[lane_c] && !air_q;
    assign top_empty = !(field_q[DEPTH-1] || field_q[2*DEPTH-1] || field_q[3*DEPTH-1]);
    assign spawn     = SPAWN_MASK[lfsr_q[3:0]] && (lfsr_q[5:4] != 2'd3) && top_empty;
    assign div_end   = (div_cnt_q == div_q - DW'(1));
    assign jump_edge = bus.jump && !jump_prev_q;
    assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_comb begin
        field_sh = '0;
        for (int l = 0; l < 3; l++) begin
            field_sh[l*DEPTH +: DEPTH] = {1'b0, field_q[l*DEPTH+1 +: DEPTH-1]};
        end
        if (spawn) begin
            field_sh[int'(lfsr_q[5:4])*DEPTH + DEPTH - 1] = 1'b1;
        end
    end

    always_comb begin
        // NOTE: every next-state value gets its hold default first, so no path leaves a latch behind.
        state_d   = state_q;
        field_d   = field_q;
        air_d     = air_q;
        air_cnt_d = air_cnt_q;
        div_d     = div_q;
        div_cnt_d = div_cnt_q;
        died_d    = 1'b0;
`ifdef OBSTACLE_SPEEDUP_EN
        shift_cnt_d = shift_cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.reset_game) begin
                    field_d   = '0;
                    air_d     = 1'b0;
                    air_cnt_d = '0;
                end
                if (bus.playing) begin
                    state_d   = RUN;
                    div_cnt_d = '0;
                    div_d     = DW'(START_DIV);
`ifdef OBSTACLE_SPEEDUP_EN
                    shift_cnt_d = '0;
`endif
                end
            end

            RUN: begin
                if (hit) begin
                    died_d  = 1'b1;
                    state_d = DEAD;
                end else if (!bus.playing) begin
                    state_d = IDLE;
                end else begin
                    if (bus.pulse) begin
                        if (div_end) begin
                            div_cnt_d = '0;
                            field_d   = field_sh;
`ifdef OBSTACLE_SPEEDUP_EN
                            shift_cnt_d = shift_cnt_q + 4'd1;
                            if (shift_cnt_q == 4'd15 && div_q > DW'(1)) begin
                                div_d = div_q - DW'(1);
                            end
`endif
                        end else begin
                            div_cnt_d = div_cnt_q + DW'(1);
                        end
                    end
                    // A fresh jump load takes priority over the airtime decrement of a coincident shift.
                    if (jump_edge && !air_q) begin
                        air_d     = 1'b1;
                        air_cnt_d = AW'(JUMP_PULSES);
                    end else if (bus.pulse && div_end && air_q) begin
                        air_cnt_d = air_cnt_q - AW'(1);
                        if (air_cnt_q == AW'(1)) begin
                            air_d = 1'b0;
                        end
                    end
                end
            end

            DEAD: begin
                if (bus.reset_game) begin
                    field_d   = '0;
                    air_d     = 1'b0;
                    air_cnt_d = '0;
                    state_d   = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst_in) begin
            state_q     <= IDLE;
            field_q     <= '0;
            lfsr_q      <= LFSR_SEED;
            air_q       <= 1'b0;
            air_cnt_q   <= '0;
            div_q       <= DW'(START_DIV);
            div_cnt_q   <= '0;
            jump_prev_q <= 1'b0;
            died_q      <= 1'b0;
`ifdef OBSTACLE_SPEEDUP_EN
            shift_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            field_q     <= field_d;
            lfsr_q      <= lfsr_d;
            air_q       <= air_d;
            air_cnt_q   <= air_cnt_d;
            div_q       <= div_d;
            div_cnt_q   <= div_cnt_d;
            jump_prev_q <= bus.jump;
            died_q      <= died_d;
`ifdef OBSTACLE_SPEEDUP_EN
            shift_cnt_q <= shift_cnt_d;
`endif
        end
    end

    assign bus.died      = died_q;
    assign bus.airborne  = air_q;
    assign bus.obstacles = field_q;
endmodule

// File: tb/tb_obstacle_engine.sv
// tb_obstacle_engine: directed bench; dut_a never spawns (airtime/divider timing), dut_b always spawns
// (field scrolling, collisions), with an LFSR and field model supplying the expected values.
module tb_obstacle_engine;
    localparam int          D     = 16;
    localparam int          JP    = 3;
    localparam int          DIV_A = 4;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    obstacle_engine_if #(.DEPTH(D)) bus_a ();
    obstacle_engine_if #(.DEPTH(D)) bus_b ();

    obstacle_engine #(
        .DEPTH(D), .JUMP_PULSES(JP), .SPAWN_THRESH(0), .LFSR_SEED(SEED), .START_DIV(DIV_A)
    ) dut_a (
        .clk_in(clk_in), .rst_in(rst_in), .bus(bus_a)
    );

    obstacle_engine #(
        .DEPTH(D), .JUMP_PULSES(JP), .SPAWN_THRESH(16), .LFSR_SEED(SEED), .START_DIV(1)
    ) dut_b (
        .clk_in(clk_in), .rst_in(rst_in), .bus(bus_b)
    );

    int             checks = 0;
    int             errors = 0;
    logic [15:0]    m_lfsr = SEED;
    logic [3*D-1:0] exp_f;

    task automatic chk(input string tag, input logic [3*D-1:0] obs, input logic [3*D-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_nxt(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Field after one shift for a design that spawns on every roll (threshold 16).
    function automatic logic [3*D-1:0] shift_f(input logic [3*D-1:0] f, input logic [15:0] lf);
        logic [3*D-1:0] n;
        n = '0;
        for (int l = 0; l < 3; l++)
            for (int r = 0; r < D - 1; r++)
                n[l*D+r] = f[l*D+r+1];
        if (lf[5:4] != 2'd3 && !(f[D-1] || f[2*D-1] || f[3*D-1]))
            n[int'(lf[5:4])*D + D - 1] = 1'b1;
        return n;
    endfunction

    // Cumulative pulse count at which shift n happens in dut_a.
    function automatic int shift_pulse(input int n);
        int p  = 0;
        int dv = DIV_A;
        for (int k = 1; k <= n; k++) begin
            p += dv;
`ifdef OBSTACLE_SPEEDUP_EN
            if (k % 16 == 0 && dv > 1) dv--;
`endif
        end
        return p;
    endfunction

    function automatic logic [1:0] safe_lane(input logic [3*D-1:0] f);
        if (!f[0] && !f[1]) return 2'd0;
        if (!f[D] && !f[D+1]) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [1:0] free_lane_row(input logic [3*D-1:0] f, input int r);
        if (!f[r]) return 2'd0;
        if (!f[D+r]) return 2'd1;
        return 2'd2;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        if (rst_in) m_lfsr = SEED;
        else        m_lfsr = lfsr_nxt(m_lfsr);
        #1;
    endtask

    task automatic b_raw_pulse();
        bus_b.pulse = 1'b1;
        tick();
        bus_b.pulse = 1'b0;
    endtask

    task automatic b_pulse();
        exp_f = shift_f(exp_f, m_lfsr);
        b_raw_pulse();
        chk("b_field", bus_b.obstacles, exp_f);
    endtask

    initial begin
        int          pc;
        int          sk;
        logic [1:0]  sl;
        logic        exp_died;
        logic        hit;
        logic        ready;

        {bus_a.pulse, bus_a.playing, bus_a.reset_game, bus_a.jump} = 4'b0;
        {bus_b.pulse, bus_b.playing, bus_b.reset_game, bus_b.jump} = 4'b0;
        bus_a.lane = 2'd0;
        bus_b.lane = 2'd0;

        // Reset and idle pulses: nothing may move while not playing.
        tick();
        tick();
        rst_in = 1'b0;
        chk("rst_died_a", bus_a.died, '0);
        chk("rst_air_a", bus_a.airborne, '0);
        chk("rst_field_a", bus_a.obstacles, '0);
        chk("rst_died_b", bus_b.died, '0);
        chk("rst_air_b", bus_b.airborne, '0);
        chk("rst_field_b", bus_b.obstacles, '0);
        for (int i = 0; i < 10; i++) begin
            bus_b.pulse = 1'b1;
            bus_a.pulse = 1'b1;
            tick();
            bus_b.pulse = 1'b0;
            bus_a.pulse = 1'b0;
            chk("idle_field_b", bus_b.obstacles, '0);
        end

        // No-spawn run: repeated jumps measure the shift period, field stays empty, no death.
        bus_a.playing = 1'b1;
        tick();
        pc = 0;
        for (int j = 1; j <= 22; j++) begin
            bus_a.jump = 1'b1;
            tick();
            bus_a.jump = 1'b0;
            tick();
            chk("a_jump_up", bus_a.airborne, 1'b1);
            for (int b = 0; b < 20; b++) begin
                bus_a.pulse = 1'b1;
                tick();
                bus_a.pulse = 1'b0;
                pc++;
                chk("a_field_zero", bus_a.obstacles, '0);
                chk("a_no_died", bus_a.died, '0);
                if (bus_a.airborne !== 1'b1) break;
            end
            chk("a_land_pulse", pc, shift_pulse(3 * j));
        end

        // Held jump: one launch only, no retrigger after landing.
        bus_a.jump = 1'b1;
        tick();
        chk("a_hold_up", bus_a.airborne, 1'b1);
        for (int b = 0; b < 20 && bus_a.airborne === 1'b1; b++) begin
            bus_a.pulse = 1'b1;
            tick();
            bus_a.pulse = 1'b0;
        end
        for (int b = 0; b < 12; b++) begin
            bus_a.pulse = 1'b1;
            tick();
            bus_a.pulse = 1'b0;
        end
        chk("a_hold_no_retrig", bus_a.airborne, 1'b0);
        bus_a.jump    = 1'b0;
        bus_a.playing = 1'b0;
        tick();

        // First spawned obstacle runs into a stationary player DEPTH-1 shifts later.
        bus_b.playing = 1'b1;
        tick();
        exp_f = '0;
        sk    = -1;
        for (int k = 0; k < 60; k++) begin
            if (sk < 0 && m_lfsr[5:4] != 2'd3) begin
                sk         = k;
                bus_b.lane = m_lfsr[5:4];
            end
            b_pulse();
            tick();
            exp_died = (sk >= 0 && k == sk + D - 1);
            chk("b_arrive_died", bus_b.died, exp_died);
            if (exp_died) break;
        end
        tick();
        chk("b_died_one_cycle", bus_b.died, 1'b0);
        for (int i = 0; i < 3; i++) b_raw_pulse();
        chk("b_dead_frozen", bus_b.obstacles, exp_f);
        bus_b.jump = 1'b1;
        tick();
        bus_b.jump = 1'b0;
        tick();
        chk("b_dead_no_jump", bus_b.airborne, 1'b0);
        bus_b.playing    = 1'b0;
        bus_b.reset_game = 1'b1;
        tick();
        bus_b.reset_game = 1'b0;
        chk("b_dead_clear", bus_b.obstacles, '0);
        tick();

        // Jump one shift before arrival: three shifts airborne, land in a clear lane.
        bus_b.playing = 1'b1;
        tick();
        exp_f = '0;
        sk    = -1;
        for (int k = 0; k < 60; k++) begin
            if (sk < 0 && m_lfsr[5:4] != 2'd3) begin
                sk         = k;
                bus_b.lane = m_lfsr[5:4];
            end
            b_pulse();
            tick();
            chk("b_approach_died", bus_b.died, 1'b0);
            if (sk >= 0 && k == sk + D - 2) break;
        end
        sl         = bus_b.lane;
        bus_b.jump = 1'b1;
        tick();
        bus_b.jump = 1'b0;
        chk("b_jump_up", bus_b.airborne, 1'b1);
        b_pulse();
        chk("b_air_s1", bus_b.airborne, 1'b1);
        chk("b_under_player", exp_f[int'(sl)*D], 1'b1);
        tick();
        chk("b_pass_died", bus_b.died, 1'b0);
        bus_b.lane = free_lane_row(exp_f, 2);
        b_pulse();
        chk("b_air_s2", bus_b.airborne, 1'b1);
        tick();
        chk("b_air_s2_died", bus_b.died, 1'b0);
        b_pulse();
        chk("b_land_s3", bus_b.airborne, 1'b0);
        tick();
        chk("b_land_died", bus_b.died, 1'b0);

        // Synchronous reset in the middle of a run.
        bus_b.playing = 1'b0;
        rst_in        = 1'b1;
        tick();
        rst_in = 1'b0;
        chk("mid_rst_field", bus_b.obstacles, '0);
        chk("mid_rst_air", bus_b.airborne, 1'b0);
        chk("mid_rst_died", bus_b.died, 1'b0);
        tick();
        chk("mid_rst_no_pulse", bus_b.died, 1'b0);

        // Lane input 3 behaves as lane 2.
        bus_b.lane    = 2'd3;
        bus_b.playing = 1'b1;
        tick();
        exp_f = '0;
        hit   = 1'b0;
        for (int k = 0; k < 80 && !hit; k++) begin
            b_pulse();
            chk("b_lane3_pre", bus_b.died, 1'b0);
            tick();
            hit = exp_f[2*D];
            chk("b_lane3_died", bus_b.died, hit);
        end
        chk("b_lane3_hit_seen", bus_b.obstacles[2*D], 1'b1);
        bus_b.playing    = 1'b0;
        bus_b.reset_game = 1'b1;
        tick();
        bus_b.reset_game = 1'b0;
        tick();

        // Dodge in lane 0 until lane 2 row 0 is occupied, then step into it.
        bus_b.lane    = 2'd0;
        bus_b.playing = 1'b1;
        tick();
        exp_f = '0;
        ready = 1'b0;
        for (int k = 0; k < 120 && !ready; k++) begin
            bus_b.lane = safe_lane(exp_f);
            b_pulse();
            tick();
            chk("b_dodge_died", bus_b.died, 1'b0);
            ready = exp_f[2*D] && (bus_b.lane == 2'd0);
        end
        bus_b.lane = 2'd2;
        tick();
        chk("b_switch_died", bus_b.died, 1'b1);
        tick();
        chk("b_switch_one_cycle", bus_b.died, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
